// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and a small magnitude helper.
package mdu_pkg;

  localparam int unsigned ITERS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  // Two's-complement magnitude when neg is set, raw value otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module mdu_div_core (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // Partial remainder stays below the divisor, so 33 bits hold the shifted
  // value and bit 32 of the trial difference is the borrow.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[32]) begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Build option MDU_FAST_MUL_EN: single-cycle 33x33 multiply instead of the
// 32-cycle shift-add multiplier; HI/LO results are identical in both builds.
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_q, rsgn_q, dz_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept, is_mul, is_div, sgn_op, last, fin, wr_hilo;
  logic [31:0] div_rem, div_quo;
  logic [63:0] mul_res;
  logic [31:0] res_hi, res_lo;

  assign accept = (state == S_IDLE) && start && !flush;
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign last   = (cnt == 6'(ITERS - 1));

  mdu_div_core u_div (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

`ifdef MDU_FAST_MUL_EN
  logic        ax_q, bx_q;
  logic [63:0] fa, fb;
  // quo_q/dvs_q carry the raw operands; ax_q/bx_q are the 33rd (extension) bits.
  assign fa      = {{32{ax_q}}, quo_q};
  assign fb      = {{32{bx_q}}, dvs_q};
  assign mul_res = fa * fb;
  localparam logic MUL_SINGLE = 1'b1;
`else
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [63:0] mul_mag;
  // Shift-add step: rem_q is the upper product half, quo_q holds the
  // remaining multiplier bits with product low bits shifting in from the top.
  assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign mul_hi  = mul_sum[32:1];
  assign mul_lo  = {mul_sum[0], quo_q[31:1]};
  assign mul_mag = {mul_hi, mul_lo};
  assign mul_res = neg_q ? (~mul_mag + 64'd1) : mul_mag;
  localparam logic MUL_SINGLE = 1'b0;
`endif

  // Final HI/LO values; division applies sign fix-up to the last step's output.
  always_comb begin
    res_hi = mul_res[63:32];
    res_lo = mul_res[31:0];
    if (state == S_DIV) begin
      res_hi = mag32(div_rem, rsgn_q);
      res_lo = mag32(div_quo, neg_q);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and completion; flush always wins over completion.
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)      state_nxt = S_MUL;
        else if (accept && is_div) state_nxt = S_DIV;
      end
      S_MUL: begin
        if (flush) state_nxt = S_IDLE;
        else if (MUL_SINGLE || last) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
        end
      end
      S_DIV: begin
        if (flush) state_nxt = S_IDLE;
        else if (dz_q || last) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divide-by-zero completes without touching HI/LO.
  assign wr_hilo = fin && !((state == S_DIV) && dz_q);

  // Operand capture, iteration datapath, counter, HI/LO and done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      rsgn_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MDU_FAST_MUL_EN
      ax_q   <= 1'b0;
      bx_q   <= 1'b0;
`endif
    end else begin
      done_q <= fin;
      if (accept) begin
        cnt <= '0;
        case (op)
          OP_MTHI: hi_q <= A;
          OP_MTLO: lo_q <= A;
          OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
            quo_q <= A;
            dvs_q <= B;
            ax_q  <= sgn_op & A[31];
            bx_q  <= sgn_op & B[31];
`else
            rem_q <= '0;
            quo_q <= mag32(B, sgn_op & B[31]);
            dvs_q <= mag32(A, sgn_op & A[31]);
            neg_q <= sgn_op & (A[31] ^ B[31]);
`endif
          end
          OP_DIV, OP_DIVU: begin
            rem_q  <= '0;
            quo_q  <= mag32(A, sgn_op & A[31]);
            dvs_q  <= mag32(B, sgn_op & B[31]);
            neg_q  <= sgn_op & (A[31] ^ B[31]);
            rsgn_q <= sgn_op & A[31];
            dz_q   <= (B == 32'd0);
          end
          default: ;
        endcase
      end else if (state == S_DIV && !flush) begin
        rem_q <= div_rem;
        quo_q <= div_quo;
        cnt   <= fin ? 6'd0 : cnt + 6'd1;
      end
`ifndef MDU_FAST_MUL_EN
      else if (state == S_MUL && !flush) begin
        rem_q <= mul_hi;
        quo_q <= mul_lo;
        cnt   <= fin ? 6'd0 : cnt + 6'd1;
      end
`endif
      if (wr_hilo) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: issue pushes expected HI/LO and latency,
// a monitor pops and compares on every done pulse.
module tb_mdu_hilo;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t_iss = 0;
  int   checks = 0;
  int   errors = 0;

  mdu_hilo dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present a request for one cycle; now=1 drives it in the current cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit now);
    if (!now) begin
      @(posedge clk); #1;
    end
    op = o; A = a; B = b; start = 1'b1;
    t_iss = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.lat = lat; e.t = t_iss;
    sb.push_back(e);
  endtask

  // Count busy cycles; returns at the negedge of the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", 64'(hi), 64'(e.hi));
        chk("sb_lo", 64'(lo), 64'(e.lo));
        chk("sb_latency", 64'(cyc - e.t), 64'(e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    resetn = 1'b1;

    // MULT -1 * 2
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    wait_idle(n); chk("mult_busy_cycles", 64'(n), 64'(MUL_LAT - 1));

    // MULTU 0xFFFFFFFF * 2
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
    expect_res(32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
    wait_idle(n);

    // DIV -7 / 2 = -3 rem -1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    wait_idle(n); chk("div_busy_cycles", 64'(n), 64'd32);

    // DIVU 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_res(32'h8000_0000, 32'h0, DIV_LAT);
    wait_idle(n);

    // DIV overflow case, no trap
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_res(32'h0, 32'h8000_0000, DIV_LAT);
    wait_idle(n);

    // MTHI / MTLO visible next cycle, no done
    issue(OP_MTHI, 32'h11, 32'h0, 1'b0);
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h11);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MTLO, 32'h22, 32'h0, 1'b0);
    @(negedge clk);
    chk("mtlo_lo", 64'(lo), 64'h22);

    // flush in IDLE suppresses a same-cycle start
    flush = 1'b1;
    issue(OP_MTHI, 32'hBAD0_BAD0, 32'h0, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_hi", 64'(hi), 64'h11);

    // divide by zero: HI/LO kept, done at T+2
    issue(OP_DIV, 32'h1234, 32'h0, 1'b0);
    expect_res(32'h11, 32'h22, 2);
    wait_idle(n); chk("dz_busy_cycles", 64'(n), 64'd1);

    // flush mid-divide; MTLO issued while busy is ignored
    issue(OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    op = OP_MTLO; A = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    repeat (40) @(negedge clk);

    // reset mid-divide
    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    chk("mthi2_hi", 64'(hi), 64'h1234_5678);
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    // recovery after reset, then back-to-back issue in the done cycle
    issue(OP_MULTU, 32'd3, 32'd5, 1'b0);
    expect_res(32'h0, 32'd15, MUL_LAT);
    wait_idle(n);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    expect_res(32'd2, 32'd14, DIV_LAT);
    wait_idle(n);
    issue(OP_MTLO, 32'h55, 32'h0, 1'b1);
    @(negedge clk);
    chk("b2b_lo", 64'(lo), 64'h55);
    chk("b2b_hi", 64'(hi), 64'd2);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
